// File: rtl/serial_detect_sched.sv
// serial_detect_sched
//
// Shares one external serial pattern detector between two requesters. A word
// is granted round-robin, optionally preceded by a detector clear pulse, then
// shifted out MSB first on xout. The detector's Moore match output (yin) is
// counted for the eight bit positions of that word, and the total is
// reported with the owning requester id.
//
// Configuration:
//   DET_FLUSH_EN  defined   -> a one-cycle CLR state pulses det_clr before
//                              every word, so no match spans two words.
//                 undefined -> no CLR state, det_clr tied low, detector
//                              history carries from word to word.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req0/req1  requester has a word pending (held until its ack)
//   data0/1    requester words
//   ack0/ack1  one-cycle grant pulse, only ever in IDLE
//   xout       serial bit to the detector
//   det_clr    synchronous clear pulse to the detector
//   yin        detector match, valid one cycle after the bit
//   res_valid  one-cycle result strobe
//   res_id     requester that owned the reported word
//   res_count  matches for that word (0..8), held until the next report
//   busy       high whenever not IDLE

module serial_detect_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       xout,
  output logic       det_clr,
  input  logic       yin,
  output logic       res_valid,
  output logic       res_id,
  output logic [3:0] res_count,
  output logic       busy
);

  localparam logic [2:0] StIdle   = 3'd0;
`ifdef DET_FLUSH_EN
  localparam logic [2:0] StClr    = 3'd1;
`endif
  localparam logic [2:0] StShift  = 3'd2;
  localparam logic [2:0] StDrain  = 3'd3;
  localparam logic [2:0] StReport = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] data_q;
  logic       id_q;
  logic       last_q;
  logic [2:0] bit_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_inc;
  logic       res_id_q;
  logic [3:0] res_count_q;
  logic       gnt0, gnt1;
  logic       enter_shift;

  // With both pending, the requester not granted last wins.
  assign gnt1 = req1 & (~req0 | ~last_q);
  assign gnt0 = req0 & ~gnt1;

  // Count saturates at 8; eight bit positions can never exceed it anyway.
  assign cnt_inc = (cnt_q == 4'd8) ? cnt_q : cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    ack0    = 1'b0;
    ack1    = 1'b0;
    case (state_q)
      StIdle: begin
        if (gnt0 || gnt1) begin
          ack0 = gnt0;
          ack1 = gnt1;
`ifdef DET_FLUSH_EN
          state_d = StClr;
`else
          state_d = StShift;
`endif
        end
      end
`ifdef DET_FLUSH_EN
      StClr:    state_d = StShift;
`endif
      StShift:  if (bit_q == 3'd0) state_d = StDrain;
      StDrain:  state_d = StReport;
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign enter_shift = (state_d == StShift) && (state_q != StShift);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      data_q      <= 8'h00;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      bit_q       <= 3'd7;
      cnt_q       <= 4'd0;
      res_id_q    <= 1'b0;
      res_count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && (gnt0 || gnt1)) begin
        data_q <= gnt1 ? data1 : data0;
        id_q   <= gnt1;
        last_q <= gnt1;
      end
      if (enter_shift) begin
        bit_q <= 3'd7;
        cnt_q <= 4'd0;
      end else if (state_q == StShift) begin
        bit_q <= bit_q - 3'd1;
        // First shift cycle sees the detector's response to older history.
        if (yin && bit_q != 3'd7) cnt_q <= cnt_inc;
      end
      // DRAIN carries the response to the last bit; fold it into the result.
      if (state_q == StDrain) begin
        res_id_q    <= id_q;
        res_count_q <= yin ? cnt_inc : cnt_q;
      end
    end
  end

  assign xout      = (state_q == StShift) & data_q[bit_q];
`ifdef DET_FLUSH_EN
  assign det_clr   = (state_q == StClr);
`else
  assign det_clr   = 1'b0;
`endif
  assign res_valid = (state_q == StReport);
  assign res_id    = res_id_q;
  assign res_count = res_count_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_detect_sched.sv
module tb_serial_detect_sched;

`ifdef DET_FLUSH_EN
  localparam int F = 1;
`else
  localparam int F = 0;
`endif
  localparam int L = 10 + F;  // grant to res_valid latency

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, xout, det_clr, yin, res_valid, res_id, busy;
  logic [3:0] res_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  serial_detect_sched dut (
    .clk(clk), .rst(rst), .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1), .xout(xout), .det_clr(det_clr),
    .yin(yin), .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Detector environment for 10111: samples xout only on bit-carrying cycles.
  logic [4:0] dhist;
  int dn, ph;
  assign yin = (dn >= 5) && (dhist == 5'b10111);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dhist <= 5'b0; dn <= 0; ph <= 0;
    end else begin
      if (det_clr) begin
        dhist <= 5'b0; dn <= 0;
      end else if (ph >= 1 + F && ph <= 8 + F) begin
        dhist <= {dhist[3:0], xout};
        if (dn < 5) dn <= dn + 1;
      end
      if (ack0 || ack1) ph <= 1;
      else if (ph != 0) ph <= (ph >= L) ? 0 : ph + 1;
    end
  end

  // Matches ending inside word w, given up to 4 earlier valid bits in prev.
  function automatic int exp_count(input logic [3:0] prev, input int pv, input logic [7:0] w);
    logic [11:0] s;
    int n, v;
    s = {prev, w};
    n = 0;
    v = (pv > 4) ? 4 : pv;
    for (int k = 4; k < 12; k++)
      if (v + (k - 4) + 1 >= 5 && s[15-k -: 5] == 5'b10111) n++;
    return n;
  endfunction

  // Transaction-level model and per-cycle compare.
  bit         m_busy = 0, m_last = 1, m_id = 0, m_rid = 0;
  int         m_p = 0, m_exp = 0, m_rcnt = 0, m_pv = 0, g;
  logic [7:0] m_word = 8'h00;
  logic [3:0] m_prev = 4'h0;
  bit         e_ack0, e_ack1, e_xout, e_clr, e_rv, e_busy;

  always @(negedge clk) begin
    e_ack0 = 0; e_ack1 = 0; e_xout = 0; e_clr = 0; e_rv = 0; e_busy = 0;
    if (rst) begin
      m_busy = 0; m_last = 1; m_rid = 0; m_rcnt = 0; m_pv = 0; m_prev = 4'h0;
    end else if (!m_busy) begin
      g = -1;
      if (req0 && req1) g = m_last ? 0 : 1;
      else if (req0) g = 0;
      else if (req1) g = 1;
      e_ack0 = (g == 0);
      e_ack1 = (g == 1);
      if (g >= 0) begin
        m_busy = 1; m_p = 1;
        m_word = (g == 1) ? data1 : data0;
        m_id = (g == 1); m_last = (g == 1);
        if (F == 1) m_pv = 0;
        m_exp = exp_count(m_prev, m_pv, m_word);
        m_prev = m_word[3:0];
        m_pv = 4;
      end
    end else begin
      e_busy = 1;
      e_clr = (F == 1) && (m_p == 1);
      if (m_p >= 1 + F && m_p <= 8 + F) e_xout = m_word[7 - (m_p - 1 - F)];
      e_rv = (m_p == L);
      if (m_p == L) begin
        m_rid = m_id; m_rcnt = m_exp; m_busy = 0;
      end else begin
        m_p++;
      end
    end
    chk("ack0", ack0, e_ack0);
    chk("ack1", ack1, e_ack1);
    chk("xout", xout, e_xout);
    chk("det_clr", det_clr, e_clr);
    chk("res_valid", res_valid, e_rv);
    chk("busy", busy, e_busy);
    chk("res_id", res_id, m_rid);
    chk("res_count", res_count, m_rcnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one word, wait for grant and report; return latency, result, shifted bits.
  task automatic do_word(input int id, input logic [7:0] d, output int lat,
                         output int rid, output int rcnt, output logic [7:0] bits);
    int  g0, p;
    bit  got;
    lat = -1; rid = -1; rcnt = -1; bits = 8'h00;
    if (id == 0) begin req0 = 1; data0 = d; end
    else begin req1 = 1; data1 = d; end
    #1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      if ((id == 0 && ack0) || (id == 1 && ack1)) got = 1;
      else begin @(posedge clk); #2; end
    end
    if (!got) chk("ack_timeout", 0, 1);
    g0 = cyc;
    tick();
    req0 = 0; req1 = 0;
    for (int i = 0; i < 20; i++) begin
      p = cyc - g0;
      if (p >= 1 + F && p <= 8 + F) bits = {bits[6:0], xout};
      if (res_valid) begin
        lat = p; rid = res_id; rcnt = res_count;
        break;
      end
      tick();
    end
    tick();
  endtask

  int lat, rid, rcnt, order[4];
  logic [7:0] bits;
  bit got;

  initial begin
    // Pin the model with hand-computed match counts.
    chk("model_b8", exp_count(4'h0, 0, 8'hB8), 1);
    chk("model_span", exp_count(4'b0001, 4, 8'h70), 1);
    chk("model_bf", exp_count(4'h0, 4, 8'hBF), 1);
    chk("model_00", exp_count(4'b1000, 4, 8'h00), 0);

    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_cnt", res_count, 0);
    rst = 0;
    tick();

    do_word(0, 8'hB8, lat, rid, rcnt, bits);
    chk("b8_latency", lat, L);
    chk("b8_bits", bits, 8'b10111000);
    chk("b8_id", rid, 0);
    chk("b8_count", rcnt, 1);

    do_word(0, 8'h00, lat, rid, rcnt, bits);
    chk("zero_count", rcnt, 0);

    do_word(1, 8'hBF, lat, rid, rcnt, bits);
    chk("bf_id", rid, 1);
    chk("bf_count", rcnt, 1);

    // Both requesting and holding: last grant was 1, so 0,1,0,1.
    data0 = 8'h5A; data1 = 8'hC3;
    req0 = 1; req1 = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      order[k] = -1;
      for (int i = 0; i < 30 && !got; i++) begin
        if (ack0 && ack1) chk("ack_overlap", 1, 0);
        if (ack0 || ack1) begin got = 1; order[k] = ack1 ? 1 : 0; end
        else begin @(posedge clk); #2; end
      end
      @(posedge clk); #2;
    end
    req0 = 0; req1 = 0;
    chk("rr0", order[0], 0);
    chk("rr1", order[1], 1);
    chk("rr2", order[2], 0);
    chk("rr3", order[3], 1);
    repeat (L + 2) tick();

    // Pattern spanning two words: only visible without the flush step.
    do_word(0, 8'h01, lat, rid, rcnt, bits);
    chk("w01_count", rcnt, 0);
    do_word(0, 8'h70, lat, rid, rcnt, bits);
`ifdef DET_FLUSH_EN
    chk("span_count", rcnt, 0);
`else
    chk("span_count", rcnt, 1);
`endif

    // Reset in SHIFT cycle 4 abandons the word.
    req1 = 1; data1 = 8'hFF;
    #1;
    chk("pre_rst_ack1", ack1, 1);
    tick();
    req1 = 0;
    repeat (3 + F) tick();
    chk("mid_shift_busy", busy, 1);
    rst = 1;
    #1;
    chk("rst_now_busy", busy, 0);
    chk("rst_now_xout", xout, 0);
    chk("rst_now_rv", res_valid, 0);
    chk("rst_now_cnt", res_count, 0);
    tick();
    rst = 0;
    tick();
    chk("post_rst_ack0", ack0, 0);
    chk("post_rst_ack1", ack1, 0);
    repeat (L + 2) begin
      chk("post_rst_rv", res_valid, 0);
      tick();
    end
    data0 = 8'h17; data1 = 8'hE8;
    req0 = 1; req1 = 1;
    #1;
    chk("post_rst_grant0", ack0, 1);
    tick();
    req0 = 0; req1 = 0;
    repeat (L + 3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
